// File: rtl/tea_iterative_encryptor.sv
// Iterative TEA encryptor: one full round per enabled clock, valid/ready on both sides.
// Block/key layout matches the pipelined TEA decryptor so ciphertext feeds it directly.
//
// state | meaning
// IDLE  | waiting for a plaintext block; in_ready follows ena
// RUN   | one TEA round per enabled edge; input ignored
// DONE  | ciphertext held on outBlock64 until out_ready; may accept the next block on the same edge
module tea_iterative_encryptor #(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E37_79B9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   inBlock64,
    input  logic [127:0]  key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   outBlock64,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(ROUNDS - 1);

    state_t        state, state_n;
    logic [31:0]   v0, v1, sum;
    logic [5:0]    cnt;
    logic [127:0]  key_q;
    logic          accept;
    logic          step;
    logic [31:0]   v0_n, v1_n;

    wire [31:0] k0 = key_q[31:0];
    wire [31:0] k1 = key_q[63:32];
    wire [31:0] k2 = key_q[95:64];
    wire [31:0] k3 = key_q[127:96];

    // The v1 half-round uses the freshly updated v0, so both halves fit in one cycle.
    always_comb begin
        v0_n = v0 + (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
        v1_n = v1 + (((v0_n << 4) + k2) ^ (v0_n + sum) ^ ((v0_n >> 5) + k3));
    end

    always_comb begin
        state_n   = state;
        step      = 1'b0;
        in_ready  = ena & ((state == IDLE) | ((state == DONE) & out_ready));
        out_valid = ena & (state == DONE);
        busy      = (state == RUN);
        accept    = in_valid & in_ready;
        case (state)
            IDLE: begin
                if (accept) state_n = RUN;
            end
            RUN: begin
                if (ena) begin
                    step = 1'b1;
                    if (cnt == LAST_CNT) state_n = DONE;
                end
            end
            DONE: begin
                if (out_valid & out_ready) state_n = accept ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0    <= '0;
            v1    <= '0;
            sum   <= '0;
            cnt   <= '0;
            key_q <= '0;
        end else if (accept) begin
            v0    <= inBlock64[31:0];
            v1    <= inBlock64[63:32];
            key_q <= key;
            sum   <= DELTA;
            cnt   <= '0;
        end else if (step) begin
            v0  <= v0_n;
            v1  <= v1_n;
            sum <= sum + DELTA;
            cnt <= cnt + 6'd1;
        end
    end

    assign outBlock64 = {v1, v0};

endmodule

// File: tb/tb_tea_iterative_encryptor.sv
// Bench for tea_iterative_encryptor: scenario tasks checked against a plain-loop TEA model.
module tb_tea_iterative_encryptor;

    localparam logic [31:0] DELTA = 32'h9E37_79B9;
    localparam logic [63:0] KAT_ZERO = 64'h94BAA940_41EA3A0A;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   inBlock64 = '0;
    logic [127:0]  key = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   outBlock64;
    logic          busy;

    int n_checks = 0;
    int n_fails  = 0;

    tea_iterative_encryptor dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inBlock64  (inBlock64),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .outBlock64 (outBlock64),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Textbook TEA: sum is bumped before each round, then y and z are mixed in turn.
    function automatic logic [63:0] tea_ref(input logic [63:0] p, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = p[31:0];
        z = p[63:32];
        s = 32'd0;
        for (int i = 0; i < 32; i++) begin
            s = s + DELTA;
            y = y + (((z << 4) + k[31:0]) ^ (z + s) ^ ((z >> 5) + k[63:32]));
            z = z + (((y << 4) + k[95:64]) ^ (y + s) ^ ((y >> 5) + k[127:96]));
        end
        return {z, y};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at a negedge; presents a block and waits (bounded) for the accept edge.
    task automatic send(input logic [63:0] blk, input logic [127:0] k, output bit ok);
        int g;
        g = 0;
        in_valid  = 1'b1;
        inBlock64 = blk;
        key       = k;
        #1;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        ok = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts enabled edges until out_valid is seen; edges=-1 on timeout.
    // viol counts cycles where ena=0 but a handshake signal was still high.
    task automatic run_to_done(input bit rand_ena, input bit scramble,
                               output int edges, output int viol);
        int g;
        g = 0;
        edges = 0;
        viol = 0;
        while (g < 400) begin
            if (rand_ena) ena = 1'($urandom_range(0, 1));
            if (scramble) begin
                key       = rnd128();
                inBlock64 = rnd64();
                in_valid  = 1'($urandom_range(0, 1));
            end
            #1;
            if (!ena && (in_ready || out_valid)) viol++;
            if (out_valid) break;
            @(posedge clk);
            if (ena) edges++;
            @(negedge clk);
            g++;
        end
        if (g >= 400) edges = -1;
        ena = 1'b1;
    endtask

    task automatic transfer();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (outBlock64 !== 64'd0) begin n_fails++; $display("FAIL reset_data: got %h expected 0", outBlock64); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_kat();
        bit ok;
        int e, v;
        send(64'd0, 128'd0, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL kat_accept: got in_ready %b expected 1", ok); end
        n_checks++;
        if (busy !== 1'b1) begin n_fails++; $display("FAIL kat_busy: got %b expected 1", busy); end
        run_to_done(1'b0, 1'b0, e, v);
        n_checks++;
        if (e != 32) begin n_fails++; $display("FAIL kat_latency: got %0d expected 32", e); end
        n_checks++;
        if (outBlock64 !== KAT_ZERO) begin n_fails++; $display("FAIL kat_data: got %h expected %h", outBlock64, KAT_ZERO); end
        n_checks++;
        if (outBlock64 !== tea_ref(64'd0, 128'd0)) begin n_fails++; $display("FAIL kat_model: got %h expected %h", outBlock64, tea_ref(64'd0, 128'd0)); end
        transfer();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL kat_idle: got ov=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        int e, v;
        send(64'd0, 128'd0, ok);
        run_to_done(1'b0, 1'b0, e, v);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || outBlock64 !== KAT_ZERO || in_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL bp_hold[%0d]: got ov=%b data=%h ir=%b expected 1 %h 0", i, out_valid, outBlock64, in_ready, KAT_ZERO);
            end
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        transfer();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_release: got ov=%b ir=%b expected 0 1", out_valid, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int e1, e2, v;
        logic [63:0]  a, b;
        logic [127:0] ka, kb;
        a = rnd64(); b = rnd64(); ka = rnd128(); kb = rnd128();
        out_ready = 1'b1;
        send(a, ka, ok);
        run_to_done(1'b0, 1'b0, e1, v);
        in_valid  = 1'b1;
        inBlock64 = b;
        key       = kb;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (outBlock64 !== tea_ref(a, ka)) begin n_fails++; $display("FAIL b2b_first: got %h expected %h", outBlock64, tea_ref(a, ka)); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_no_bubble: got busy=%b ov=%b expected 1 0", busy, out_valid);
        end
        run_to_done(1'b0, 1'b0, e2, v);
        n_checks++;
        if (e2 + 1 != 33) begin n_fails++; $display("FAIL b2b_period: got %0d expected 33", e2 + 1); end
        n_checks++;
        if (outBlock64 !== tea_ref(b, kb)) begin n_fails++; $display("FAIL b2b_second: got %h expected %h", outBlock64, tea_ref(b, kb)); end
        transfer();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_idle: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_key_isolation();
        bit ok;
        int e, v;
        logic [63:0]  p;
        logic [127:0] k;
        for (int i = 0; i < 4; i++) begin
            p = rnd64();
            k = rnd128();
            send(p, k, ok);
            run_to_done(1'b0, 1'b1, e, v);
            in_valid = 1'b0;
            n_checks++;
            if (outBlock64 !== tea_ref(p, k)) begin
                n_fails++;
                $display("FAIL keyiso[%0d]: got %h expected %h", i, outBlock64, tea_ref(p, k));
            end
            transfer();
            @(negedge clk);
        end
    endtask

    task automatic test_ena_gaps();
        bit ok;
        int e, v;
        send(64'd0, 128'd0, ok);
        run_to_done(1'b1, 1'b0, e, v);
        n_checks++;
        if (e != 32) begin n_fails++; $display("FAIL ena_latency: got %0d expected 32", e); end
        n_checks++;
        if (v != 0) begin n_fails++; $display("FAIL ena_handshake: got %0d cycles with ena=0 handshake, expected 0", v); end
        n_checks++;
        if (outBlock64 !== KAT_ZERO) begin n_fails++; $display("FAIL ena_data: got %h expected %h", outBlock64, KAT_ZERO); end
        ena = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ena = 1'b1;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fails++; $display("FAIL ena_frozen_xfer: got ov=%b expected 1", out_valid); end
        transfer();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int e, v;
        send(rnd64(), rnd128(), ok);
        repeat (17) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (outBlock64 !== 64'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL midrst_outputs: got data=%h ov=%b busy=%b expected 0 0 0", outBlock64, out_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        send(64'd0, 128'd0, ok);
        run_to_done(1'b0, 1'b0, e, v);
        n_checks++;
        if (e != 32 || outBlock64 !== KAT_ZERO) begin
            n_fails++;
            $display("FAIL midrst_kat: got lat=%0d data=%h expected 32 %h", e, outBlock64, KAT_ZERO);
        end
        transfer();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_kat();
        test_backpressure();
        test_back_to_back();
        test_key_isolation();
        test_ena_gaps();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
